// File: rtl/window_spill_ctrl.sv
// Register-window overflow/underflow sequencer: spills a 16-register window
// (locals + ins) to the stack on SAVE overflow, fills it back on RESTORE underflow.
module window_spill_ctrl #(
  parameter int NWINDOWS   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  save_req_i,
  input  logic                  restore_req_i,
  input  logic [4:0]            cwp_in_i,
  input  logic [31:0]           wim_in_i,
  input  logic [31:0]           base_addr_i,
  output logic                  rf_rd_en_o,
  output logic [4:0]            rf_rd_win_o,
  output logic [3:0]            rf_rd_idx_o,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_i,
  output logic                  rf_wr_en_o,
  output logic [4:0]            rf_wr_win_o,
  output logic [3:0]            rf_wr_idx_o,
  output logic [DATA_WIDTH-1:0] rf_wr_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  wim_wr_en_o,
  output logic [31:0]           wim_wr_data_o,
  output logic                  cwp_dec_o,
  output logic                  cwp_inc_o
);

  typedef enum logic [2:0] {IDLE, SP_RD, SP_WR, FL_REQ, FL_WAIT, DONE} state_e;

  localparam logic [4:0] LAST_WIN = 5'(NWINDOWS - 1);
  localparam logic [3:0] LAST_IDX = 4'd15;

  state_e                state_q;
  logic [4:0]            tgt_q;
  logic [31:0]           base_q;
  logic [3:0]            idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wfirst_q;

  logic                  busy_q;
  logic                  rf_rd_en_q;
  logic [4:0]            rf_rd_win_q;
  logic [3:0]            rf_rd_idx_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [31:0]           mem_addr_q;
  logic                  wim_wr_en_q;
  logic [31:0]           wim_wr_data_q;
  logic                  cwp_dec_q;
  logic                  cwp_inc_q;

  // Window numbers wrap modulo NWINDOWS; cwp_in is taken to be a legal window.
  function automatic logic [4:0] win_dec(input logic [4:0] w);
    return (w == 5'd0) ? LAST_WIN : w - 5'd1;
  endfunction

  function automatic logic [4:0] win_inc(input logic [4:0] w);
    return (w == LAST_WIN) ? 5'd0 : w + 5'd1;
  endfunction

  function automatic logic [31:0] slot_addr(input logic [31:0] base, input logic [3:0] idx);
    return base + {26'd0, idx, 2'b00};
  endfunction

  logic [4:0] save_tgt, rest_tgt;
  logic [3:0] idx_d;

  assign save_tgt = win_dec(cwp_in_i);
  assign rest_tgt = win_inc(cwp_in_i);
  assign idx_d    = idx_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      base_q        <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      wfirst_q      <= 1'b0;
      busy_q        <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_rd_win_q   <= '0;
      rf_rd_idx_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      wim_wr_en_q   <= 1'b0;
      wim_wr_data_q <= '0;
      cwp_dec_q     <= 1'b0;
      cwp_inc_q     <= 1'b0;
    end else begin
      // single-cycle strobes fall unless the transition below re-raises them
      rf_rd_en_q    <= 1'b0;
      rf_rd_win_q   <= '0;
      rf_rd_idx_q   <= '0;
      wim_wr_en_q   <= 1'b0;
      wim_wr_data_q <= '0;
      cwp_dec_q     <= 1'b0;
      cwp_inc_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (save_req_i) begin
            if (wim_in_i[save_tgt]) begin
              state_q     <= SP_RD;
              tgt_q       <= save_tgt;
              base_q      <= base_addr_i;
              idx_q       <= '0;
              busy_q      <= 1'b1;
              rf_rd_en_q  <= 1'b1;
              rf_rd_win_q <= save_tgt;
            end else begin
              cwp_dec_q <= 1'b1;
            end
          end else if (restore_req_i) begin
            if (wim_in_i[rest_tgt]) begin
              state_q    <= FL_REQ;
              tgt_q      <= rest_tgt;
              base_q     <= base_addr_i;
              idx_q      <= '0;
              busy_q     <= 1'b1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= base_addr_i;
            end else begin
              cwp_inc_q <= 1'b1;
            end
          end
        end
        SP_RD: begin
          state_q    <= SP_WR;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b1;
          mem_addr_q <= slot_addr(base_q, idx_q);
          wfirst_q   <= 1'b1;
        end
        SP_WR: begin
          // read data is only valid in the first SP_WR cycle; hold it for a slow grant
          if (wfirst_q) begin
            wdata_q  <= rf_rd_data_i;
            wfirst_q <= 1'b0;
          end
          if (mem_gnt_i) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            wfirst_q   <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q       <= DONE;
              wim_wr_en_q   <= 1'b1;
              wim_wr_data_q <= 32'd1 << win_dec(tgt_q);
              cwp_dec_q     <= 1'b1;
            end else begin
              state_q     <= SP_RD;
              idx_q       <= idx_d;
              rf_rd_en_q  <= 1'b1;
              rf_rd_win_q <= tgt_q;
              rf_rd_idx_q <= idx_d;
            end
          end
        end
        FL_REQ: begin
          if (mem_gnt_i) begin
            state_q    <= FL_WAIT;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        FL_WAIT: begin
          if (mem_rvalid_i) begin
            if (idx_q == LAST_IDX) begin
              state_q       <= DONE;
              wim_wr_en_q   <= 1'b1;
              wim_wr_data_q <= 32'd1 << win_inc(tgt_q);
              cwp_inc_q     <= 1'b1;
            end else begin
              state_q    <= FL_REQ;
              idx_q      <= idx_d;
              mem_req_q  <= 1'b1;
              mem_addr_q <= slot_addr(base_q, idx_d);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic in_sp_wr, fl_beat;

  assign in_sp_wr = (state_q == SP_WR);
  assign fl_beat  = (state_q == FL_WAIT) && mem_rvalid_i;

  assign busy_o        = busy_q;
  assign rf_rd_en_o    = rf_rd_en_q;
  assign rf_rd_win_o   = rf_rd_win_q;
  assign rf_rd_idx_o   = rf_rd_idx_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = !in_sp_wr ? '0 : (wfirst_q ? rf_rd_data_i : wdata_q);
  assign rf_wr_en_o    = fl_beat;
  assign rf_wr_win_o   = fl_beat ? tgt_q : '0;
  assign rf_wr_idx_o   = fl_beat ? idx_q : '0;
  assign rf_wr_data_o  = fl_beat ? mem_rdata_i : '0;
  assign wim_wr_en_o   = wim_wr_en_q;
  assign wim_wr_data_o = wim_wr_data_q;
  assign cwp_dec_o     = cwp_dec_q;
  assign cwp_inc_o     = cwp_inc_q;

endmodule

// File: tb/tb_window_spill_ctrl.sv
// Bench for window_spill_ctrl: regfile and memory behavioural models, a transaction
// log, and expectations derived from the window/stack arithmetic.
module tb_window_spill_ctrl;
  localparam int NW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          save_req, restore_req;
  logic [4:0]    cwp_in;
  logic [31:0]   wim_in, base_addr;
  logic          rf_rd_en;
  logic [4:0]    rf_rd_win;
  logic [3:0]    rf_rd_idx;
  logic [DW-1:0] rf_rd_data;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_win;
  logic [3:0]    rf_wr_idx;
  logic [DW-1:0] rf_wr_data;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, wim_wr_en;
  logic [31:0]   wim_wr_data;
  logic          cwp_dec, cwp_inc;

  window_spill_ctrl #(.NWINDOWS(NW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .save_req_i(save_req), .restore_req_i(restore_req),
    .cwp_in_i(cwp_in), .wim_in_i(wim_in), .base_addr_i(base_addr),
    .rf_rd_en_o(rf_rd_en), .rf_rd_win_o(rf_rd_win), .rf_rd_idx_o(rf_rd_idx),
    .rf_rd_data_i(rf_rd_data),
    .rf_wr_en_o(rf_wr_en), .rf_wr_win_o(rf_wr_win), .rf_wr_idx_o(rf_wr_idx),
    .rf_wr_data_o(rf_wr_data),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .wim_wr_en_o(wim_wr_en), .wim_wr_data_o(wim_wr_data),
    .cwp_dec_o(cwp_dec), .cwp_inc_o(cwp_inc)
  );

  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [DW-1:0] rf_mem [NW][16];
  logic [DW-1:0] mem_arr [logic [31:0]];
  bit            gnt_rand = 1'b0, spur_en = 1'b0;
  int            rd_lat = 1, stall_left = 0;
  logic [31:0]   stall_addr = '0;
  logic          rd_pend = 1'b0;
  logic [4:0]    rd_w = '0;
  logic [3:0]    rd_i = '0;
  bit            rv_pend = 1'b0;
  int            rv_cnt = 0;
  logic [DW-1:0] rv_data = '0;

  always @(negedge clk) begin
    rd_pend = rf_rd_en;
    rd_w    = rf_rd_win;
    rd_i    = rf_rd_idx;
  end

  // Read data is only meaningful the cycle after a read; otherwise it is noise.
  always @(posedge clk) begin
    #2;
    rf_rd_data = (rd_pend === 1'b1 && rd_w < 5'(NW)) ? rf_mem[rd_w[2:0]][rd_i] : DW'($urandom);
  end

  always @(posedge clk) begin
    #2;
    mem_rvalid = 1'b0;
    mem_rdata  = DW'($urandom);
    if (rv_pend) begin
      if (rv_cnt <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_data;
        rv_pend    = 1'b0;
      end else rv_cnt--;
    end else if (spur_en && $urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
    mem_gnt = 1'b0;
    if (mem_req === 1'b1) begin
      if (stall_left > 0 && mem_addr == stall_addr) stall_left--;
      else mem_gnt = gnt_rand ? 1'($urandom) : 1'b1;
      if (mem_gnt && !mem_we) begin
        rv_pend = 1'b1;
        rv_cnt  = rd_lat;
        rv_data = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- monitor ----------------
  int            ncyc = 0, busy_cnt, dec_cnt, inc_cnt, wim_cnt, stab_err, pulse_cyc;
  logic [31:0]   wim_last;
  logic [63:0]   wr_log [$];
  logic [40:0]   rfw_log [$];
  bit            hold_prev = 1'b0;
  logic [31:0]   prev_addr;
  logic [DW-1:0] prev_wdata;
  logic          prev_we;

  always @(negedge clk) begin
    ncyc++;
    if (busy === 1'b1) busy_cnt++;
    if ((cwp_dec === 1'b1 || cwp_inc === 1'b1) && dec_cnt + inc_cnt == 0) pulse_cyc = ncyc;
    if (cwp_dec === 1'b1) dec_cnt++;
    if (cwp_inc === 1'b1) inc_cnt++;
    if (wim_wr_en === 1'b1) begin wim_cnt++; wim_last = wim_wr_data; end
    if (mem_req === 1'b1 && mem_we === 1'b1 && mem_gnt) wr_log.push_back({mem_addr, mem_wdata});
    if (rf_wr_en === 1'b1) rfw_log.push_back({rf_wr_win, rf_wr_idx, rf_wr_data});
    if (hold_prev && !(mem_req === 1'b1 && mem_addr === prev_addr &&
                       mem_wdata === prev_wdata && mem_we === prev_we)) stab_err++;
    hold_prev  = (mem_req === 1'b1) && !mem_gnt;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_we    = mem_we;
  end

  // ---------------- checking helpers ----------------
  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    busy_cnt = 0; dec_cnt = 0; inc_cnt = 0; wim_cnt = 0; stab_err = 0; pulse_cyc = 0;
    wim_last = '0; hold_prev = 1'b0;
    wr_log.delete();
    rfw_log.delete();
  endtask

  task automatic prefill(input logic [31:0] base);
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      a = base + 32'(4 * i);
      mem_arr[a] = DW'($urandom);
    end
  endtask

  // Issue one request, run until the commit pulse (bounded), with optional
  // request noise while busy that the controller must ignore.
  task automatic run_op(input bit sv, input bit rs, input int cwp, input logic [31:0] wim,
                        input logic [31:0] base, input bit noise,
                        output bit timed_out, output int lat);
    int req_at;
    clear_logs();
    save_req = sv; restore_req = rs; cwp_in = 5'(cwp); wim_in = wim; base_addr = base;
    req_at = ncyc;
    tick();
    save_req = 1'b0; restore_req = 1'b0; base_addr = $urandom;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dec_cnt + inc_cnt > 0) begin timed_out = 1'b0; break; end
      tick();
      if (noise && busy === 1'b1) begin
        save_req = 1'($urandom); restore_req = 1'($urandom);
      end else begin
        save_req = 1'b0; restore_req = 1'b0;
      end
    end
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    tick();
    lat = pulse_cyc - req_at - 1;
  endtask

  task automatic check_spill(input string tag, input int t, input logic [31:0] base, input bit to);
    chk({tag, ".timeout"}, 64'(to), 64'd0);
    chk({tag, ".nwrites"}, 64'(wr_log.size()), 64'd16);
    for (int i = 0; i < 16 && i < wr_log.size(); i++)
      chk($sformatf("%s.wr%0d", tag, i), wr_log[i], {base + 32'(4 * i), rf_mem[t][i]});
    chk({tag, ".wimdata"}, 64'(wim_last), 64'(32'd1 << ((t + NW - 1) % NW)));
    chk({tag, ".wimcnt"}, 64'(wim_cnt), 64'd1);
    chk({tag, ".deccnt"}, 64'(dec_cnt), 64'd1);
    chk({tag, ".inccnt"}, 64'(inc_cnt), 64'd0);
    chk({tag, ".rfwr"}, 64'(rfw_log.size()), 64'd0);
    chk({tag, ".stable"}, 64'(stab_err), 64'd0);
  endtask

  task automatic check_fill(input string tag, input int t, input logic [31:0] base, input bit to);
    logic [31:0] a;
    chk({tag, ".timeout"}, 64'(to), 64'd0);
    chk({tag, ".nrfwr"}, 64'(rfw_log.size()), 64'd16);
    for (int i = 0; i < 16 && i < rfw_log.size(); i++) begin
      a = base + 32'(4 * i);
      chk($sformatf("%s.rf%0d", tag, i), 64'(rfw_log[i]), 64'({5'(t), 4'(i), mem_arr[a]}));
    end
    chk({tag, ".wimdata"}, 64'(wim_last), 64'(32'd1 << ((t + 1) % NW)));
    chk({tag, ".wimcnt"}, 64'(wim_cnt), 64'd1);
    chk({tag, ".inccnt"}, 64'(inc_cnt), 64'd1);
    chk({tag, ".deccnt"}, 64'(dec_cnt), 64'd0);
    chk({tag, ".memwr"}, 64'(wr_log.size()), 64'd0);
    chk({tag, ".stable"}, 64'(stab_err), 64'd0);
  endtask

  task automatic check_fast(input string tag, input bit is_dec, input int lat, input bit to);
    chk({tag, ".timeout"}, 64'(to), 64'd0);
    chk({tag, ".busy"}, 64'(busy_cnt), 64'd0);
    chk({tag, ".latency"}, 64'(lat), 64'd1);
    chk({tag, ".deccnt"}, 64'(dec_cnt), 64'(is_dec));
    chk({tag, ".inccnt"}, 64'(inc_cnt), 64'(!is_dec));
    chk({tag, ".wimcnt"}, 64'(wim_cnt), 64'd0);
    chk({tag, ".traffic"}, 64'(wr_log.size() + rfw_log.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit          to, found;
    int          lat, cwp, op, t;
    logic [31:0] wim, base;

    for (int w = 0; w < NW; w++)
      for (int i = 0; i < 16; i++) rf_mem[w][i] = DW'($urandom);
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    cwp_in = '0; wim_in = '0; base_addr = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.mem_req", 64'(mem_req), 64'd0);
    chk("reset.rf_rd_en", 64'(rf_rd_en), 64'd0);
    chk("reset.rf_wr_en", 64'(rf_wr_en), 64'd0);
    chk("reset.wim_wr_en", 64'(wim_wr_en), 64'd0);
    chk("reset.cwp", 64'({cwp_dec, cwp_inc}), 64'd0);
    chk("reset.mem_addr", 64'(mem_addr), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // SAVE into a valid window: immediate commit, never busy
    run_op(1'b1, 1'b0, 3, 32'h01, 32'h0, 1'b0, to, lat);
    check_fast("save_fast", 1'b1, lat, to);
    run_op(1'b0, 1'b1, 2, 32'h01, 32'h0, 1'b0, to, lat);
    check_fast("rest_fast", 1'b0, lat, to);

    // Zero-wait spill of window 0
    run_op(1'b1, 1'b0, 1, 32'h01, 32'h1000, 1'b0, to, lat);
    check_spill("spill0", 0, 32'h1000, to);
    chk("spill0.wim80", 64'(wim_last), 64'h80);
    chk("spill0.busycyc", 64'(busy_cnt), 64'd33);
    chk("spill0.latency", 64'(lat), 64'd33);

    // Fill of window 7 with read data two cycles after each grant
    rd_lat = 2;
    prefill(32'h2000);
    run_op(1'b0, 1'b1, 6, 32'h80, 32'h2000, 1'b0, to, lat);
    check_fill("fill7", 7, 32'h2000, to);
    chk("fill7.wim01", 64'(wim_last), 64'h01);

    // Grant withheld for 5 cycles on slot 4
    stall_addr = 32'h3010; stall_left = 5;
    run_op(1'b1, 1'b0, 1, 32'h01, 32'h3000, 1'b0, to, lat);
    check_spill("stall", 0, 32'h3000, to);
    chk("stall.consumed", 64'(stall_left), 64'd0);
    chk("stall.busycyc", 64'(busy_cnt), 64'd38);

    // SAVE and RESTORE together: SAVE wins
    run_op(1'b1, 1'b1, 3, 32'h0, 32'h0, 1'b0, to, lat);
    check_fast("both", 1'b1, lat, to);

    // Reset in the middle of a spill at slot 7
    clear_logs();
    save_req = 1'b1; cwp_in = 5'd1; wim_in = 32'h01; base_addr = 32'h4000;
    tick();
    save_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rf_rd_en === 1'b1 && rf_rd_idx === 4'd7) begin found = 1'b1; break; end
      tick();
    end
    chk("abort.reach7", 64'(found), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.mem_req", 64'(mem_req), 64'd0);
    chk("abort.rf_rd_en", 64'(rf_rd_en), 64'd0);
    repeat (4) tick();
    chk("abort.wimcnt", 64'(wim_cnt), 64'd0);
    chk("abort.cwp", 64'(dec_cnt + inc_cnt), 64'd0);
    chk("abort.partial", 64'(wr_log.size()), 64'd7);
    run_op(1'b1, 1'b0, 1, 32'h01, 32'h5000, 1'b0, to, lat);
    check_spill("after_abort", 0, 32'h5000, to);
    chk("after_abort.busycyc", 64'(busy_cnt), 64'd33);

    // Randomized operations: random grants, read latency, spurious rvalid,
    // request noise while busy, and one base that wraps past 2^32
    spur_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cwp  = $urandom_range(0, NW - 1);
      op   = $urandom_range(0, 2);
      wim  = $urandom;
      t    = (op != 1) ? (cwp + NW - 1) % NW : (cwp + 1) % NW;
      if ($urandom_range(0, 3) != 0) wim[t] = 1'b1;
      base = (k == 2) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC);
      gnt_rand = 1'($urandom);
      rd_lat   = $urandom_range(1, 3);
      for (int i = 0; i < 16; i++) rf_mem[t][i] = DW'($urandom);
      prefill(base);
      run_op(op != 1, op != 0, cwp, wim, base, 1'b1, to, lat);
      if (!wim[t])      check_fast($sformatf("rnd%0d.fast", k), op != 1, lat, to);
      else if (op != 1) check_spill($sformatf("rnd%0d.spill", k), t, base, to);
      else              check_fill($sformatf("rnd%0d.fill", k), t, base, to);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/window_spill_ctrl.md
WINDOW_SPILL_CTRL -- requirements
Module: window_spill_ctrl

Interface
REQ-001 Parameter NWINDOWS, default 8, number of register windows (2..32).
REQ-002 Parameter DATA_WIDTH, default 32, register/memory word width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 save_req  input  1  decode holds a SAVE, one-cycle pulse.
REQ-006 restore_req  input  1  decode holds a RESTORE, one-cycle pulse.
REQ-007 cwp_in  input  5  current window pointer.
REQ-008 wim_in  input  32  window invalid mask; bits >= NWINDOWS ignored.
REQ-009 base_addr  input  32  stack base for spill/fill, sampled with the request.
REQ-010 rf_rd_en / rf_rd_win[4:0] / rf_rd_idx[3:0]  output  regfile read port; idx 0-7 locals, 8-15 ins.
REQ-011 rf_rd_data  input  DATA_WIDTH  read data, valid one cycle after rf_rd_en.
REQ-012 rf_wr_en / rf_wr_win[4:0] / rf_wr_idx[3:0] / rf_wr_data[DATA_WIDTH]  output  regfile write port.
REQ-013 mem_req / mem_we / mem_addr[32] / mem_wdata[DATA_WIDTH]  output  memory request.
REQ-014 mem_gnt  input  1  request accepted this cycle.
REQ-015 mem_rvalid / mem_rdata[DATA_WIDTH]  input  read data return.
REQ-016 busy  output  1  stall decode; high in every non-IDLE state.
REQ-017 wim_wr_en / wim_wr_data[32]  output  one-cycle WIM update.
REQ-018 cwp_dec / cwp_inc  output  1  one-cycle pulse committing SAVE / RESTORE.

Function
REQ-019 States: IDLE, SP_RD, SP_WR, FL_REQ, FL_WAIT, DONE.
REQ-020 In IDLE, save_req: target T = (cwp_in-1) mod NWINDOWS; if wim_in[T]=0 -> cwp_dec pulses next cycle, state stays IDLE, busy stays 0.
REQ-021 In IDLE, restore_req: T = (cwp_in+1) mod NWINDOWS; if wim_in[T]=0 -> cwp_inc pulses next cycle, no busy.
REQ-022 Overflow (save, wim_in[T]=1): latch T, base_addr, idx=0, enter SP_RD.
REQ-023 Underflow (restore, wim_in[T]=1): latch T, base_addr, idx=0, enter FL_REQ.
REQ-024 save_req and restore_req together in IDLE: save wins; restore dropped.
REQ-025 Requests arriving outside IDLE are ignored (decode is stalled by busy).
REQ-026 SP_RD: rf_rd_en=1, rf_rd_win=T, rf_rd_idx=idx for one cycle; then SP_WR.
REQ-027 SP_WR: mem_req=1, mem_we=1, mem_addr=base+4*idx, mem_wdata=captured rf_rd_data; held stable until mem_gnt.
REQ-028 On mem_gnt in SP_WR: idx<15 -> idx+1, SP_RD; idx=15 -> DONE.
REQ-029 FL_REQ: mem_req=1, mem_we=0, mem_addr=base+4*idx held until mem_gnt, then FL_WAIT.
REQ-030 FL_WAIT: on mem_rvalid, rf_wr_en=1 same cycle, rf_wr_win=T, rf_wr_idx=idx, rf_wr_data=mem_rdata; idx<15 -> FL_REQ, idx=15 -> DONE.
REQ-031 mem_rvalid outside FL_WAIT is ignored.
REQ-032 Address arithmetic 32-bit, wraps modulo 2^32.
REQ-033 DONE (one cycle): wim_wr_en=1; wim_wr_data has single bit set, (T-1) mod N after spill, (T+1) mod N after fill; cwp_dec (spill) or cwp_inc (fill) pulses; next state IDLE.
REQ-034 Spill latency with zero-wait grant: 2 cycles/register, 32 + 1 DONE cycle.
REQ-035 All outputs not driven by the current state are 0.

Reset
REQ-036 reset forces IDLE, idx=0, and all outputs to 0 on the next edge, including mid-operation.
REQ-037 An operation aborted by reset issues no wim_wr_en, cwp_inc or cwp_dec.

Verification
REQ-038 cwp=3, wim=0x01, save_req -> cwp_dec one cycle later, busy never high.
REQ-039 cwp=1, wim=0x01, base=0x1000, save_req, gnt always 1 -> 16 writes to 0x1000..0x103C with window-0 data; DONE gives wim_wr_data=0x80, cwp_dec=1; busy high 33 cycles.
REQ-040 cwp=6, wim=0x80, base=0x2000, restore_req, rvalid 2 cycles after each gnt -> 16 regfile writes to window 7, idx 0..15; wim_wr_data=0x01, cwp_inc=1.
REQ-041 Spill with mem_gnt withheld 5 cycles on idx 4 -> mem_addr/mem_wdata stable throughout; no idx skipped or repeated.
REQ-042 save_req and restore_req in same cycle, wim=0 -> only cwp_dec pulses.
REQ-043 reset asserted at idx=7 of a spill -> IDLE next edge, busy=0, no wim or cwp pulse; new save_req then completes normally.
